// File: rtl/mac_tile_sequencer.sv
// Tile sequencer for a column of MAC units: loads a weight chain, commits it,
// streams activations and tracks the multiplier pipeline until the tile drains.
module mac_tile_sequencer #(
  parameter int ARRAY_ROWS     = 16,
  parameter int TILE_LEN_WIDTH = 16,
  parameter int ACC_LATENCY    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [TILE_LEN_WIDTH-1:0] tile_len,
  input  logic                      abort,
  input  logic                      w_valid,
  output logic                      w_ready,
  output logic                      prepare_weight,
  output logic                      set_weight,
  input  logic                      a_valid,
  output logic                      a_ready,
  output logic                      act_fire,
  output logic                      acc_valid,
  output logic                      acc_last,
  output logic                      busy,
  output logic                      done
);

  localparam int WCNT_W = (ARRAY_ROWS > 1) ? $clog2(ARRAY_ROWS) : 1;
  localparam int DCNT_W = (ACC_LATENCY > 1) ? $clog2(ACC_LATENCY) : 1;

  localparam logic [WCNT_W-1:0]         WCNT_LAST = WCNT_W'(ARRAY_ROWS - 1);
  localparam logic [WCNT_W-1:0]         WCNT_ONE  = WCNT_W'(1);
  localparam logic [DCNT_W-1:0]         DCNT_LAST = DCNT_W'(ACC_LATENCY - 1);
  localparam logic [DCNT_W-1:0]         DCNT_ONE  = DCNT_W'(1);
  localparam logic [TILE_LEN_WIDTH-1:0] ACNT_ONE  = TILE_LEN_WIDTH'(1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_ARM    = 3'd2,
    ST_STREAM = 3'd3,
    ST_DRAIN  = 3'd4
  } state_e;

  state_e                    state_q, state_d;
  logic [WCNT_W-1:0]         wcnt_q, wcnt_d;
  logic [TILE_LEN_WIDTH-1:0] acnt_q, acnt_d;
  logic [TILE_LEN_WIDTH-1:0] len_q, len_d;
  logic [DCNT_W-1:0]         dcnt_q, dcnt_d;
  logic [ACC_LATENCY-1:0]    vld_sr_q, vld_sr_d;
  logic [ACC_LATENCY-1:0]    last_sr_q, last_sr_d;

  logic len_zero_s;
  logic wcnt_last_s;
  logic acnt_last_s;
  logic dcnt_last_s;
  logic last_fire_s;

  assign len_zero_s  = (len_q == {TILE_LEN_WIDTH{1'b0}});
  assign wcnt_last_s = (wcnt_q == WCNT_LAST);
  assign acnt_last_s = (acnt_q == (len_q - ACNT_ONE));
  assign dcnt_last_s = (dcnt_q == DCNT_LAST);

  // Handshake fires are pure ANDs of the valid inputs with state-decoded readies.
  assign prepare_weight = w_valid & w_ready;
  assign act_fire       = a_valid & a_ready;
  assign last_fire_s    = act_fire & acnt_last_s;

  assign acc_valid = vld_sr_q[ACC_LATENCY-1];
  assign acc_last  = last_sr_q[ACC_LATENCY-1];

  // State, counters, captured length and result shift lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      wcnt_q    <= {WCNT_W{1'b0}};
      acnt_q    <= {TILE_LEN_WIDTH{1'b0}};
      len_q     <= {TILE_LEN_WIDTH{1'b0}};
      dcnt_q    <= {DCNT_W{1'b0}};
      vld_sr_q  <= {ACC_LATENCY{1'b0}};
      last_sr_q <= {ACC_LATENCY{1'b0}};
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      acnt_q    <= acnt_d;
      len_q     <= len_d;
      dcnt_q    <= dcnt_d;
      vld_sr_q  <= vld_sr_d;
      last_sr_q <= last_sr_d;
    end
  end

  // Next-state and counter update; abort overrides everything including start.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    acnt_d  = acnt_q;
    len_d   = len_q;
    dcnt_d  = dcnt_q;
    if (abort) begin
      state_d = ST_IDLE;
      wcnt_d  = {WCNT_W{1'b0}};
      acnt_d  = {TILE_LEN_WIDTH{1'b0}};
      len_d   = {TILE_LEN_WIDTH{1'b0}};
      dcnt_d  = {DCNT_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            len_d   = tile_len;
            wcnt_d  = {WCNT_W{1'b0}};
            acnt_d  = {TILE_LEN_WIDTH{1'b0}};
            dcnt_d  = {DCNT_W{1'b0}};
            state_d = ST_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (prepare_weight) begin
            if (wcnt_last_s) begin
              wcnt_d  = {WCNT_W{1'b0}};
              state_d = ST_ARM;
            end else begin
              wcnt_d = wcnt_q + WCNT_ONE;
            end
          end else begin
            wcnt_d = wcnt_q;
          end
        end
        ST_ARM: begin
          if (len_zero_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_STREAM;
          end
        end
        ST_STREAM: begin
          // acnt tops out at tile_len, so it never wraps even at the maximum length.
          if (act_fire) begin
            acnt_d = acnt_q + ACNT_ONE;
            if (acnt_last_s) begin
              state_d = ST_DRAIN;
            end else begin
              state_d = ST_STREAM;
            end
          end else begin
            acnt_d = acnt_q;
          end
        end
        ST_DRAIN: begin
          if (dcnt_last_s) begin
            dcnt_d  = {DCNT_W{1'b0}};
            state_d = ST_IDLE;
          end else begin
            dcnt_d = dcnt_q + DCNT_ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          wcnt_d  = {WCNT_W{1'b0}};
          acnt_d  = {TILE_LEN_WIDTH{1'b0}};
          dcnt_d  = {DCNT_W{1'b0}};
        end
      endcase
    end
  end

  // Result shift lines mirror the multiplier pipeline depth.
  always_comb begin
    vld_sr_d  = {ACC_LATENCY{1'b0}};
    last_sr_d = {ACC_LATENCY{1'b0}};
    if (abort) begin
      vld_sr_d  = {ACC_LATENCY{1'b0}};
      last_sr_d = {ACC_LATENCY{1'b0}};
    end else begin
      vld_sr_d[0]  = act_fire;
      last_sr_d[0] = last_fire_s;
      for (int i = 1; i < ACC_LATENCY; i++) begin
        vld_sr_d[i]  = vld_sr_q[i-1];
        last_sr_d[i] = last_sr_q[i-1];
      end
    end
  end

  // Ready, commit and status outputs decoded from registered state only.
  always_comb begin
    w_ready    = 1'b0;
    a_ready    = 1'b0;
    set_weight = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
      end
      ST_LOAD: begin
        busy    = 1'b1;
        w_ready = 1'b1;
      end
      ST_ARM: begin
        busy       = 1'b1;
        set_weight = 1'b1;
        done       = len_zero_s;
      end
      ST_STREAM: begin
        busy    = 1'b1;
        a_ready = 1'b1;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        done = dcnt_last_s;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mac_tile_sequencer.sv
// Directed bench for mac_tile_sequencer: per-cycle output traces of each tile
// are compared against hand-derived cycle masks (bit c = cycle c after start).
module tb_mac_tile_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] tile_len = 16'd0;
  logic        start4 = 1'b0;
  logic [3:0]  tile_len4 = 4'd0;
  logic        abort = 1'b0;
  logic        w_valid = 1'b0;
  logic        a_valid = 1'b0;

  logic w_ready, prepare_weight, set_weight, a_ready, act_fire;
  logic acc_valid, acc_last, busy, done;
  logic w_ready4, prepare_weight4, set_weight4, a_ready4, act_fire4;
  logic acc_valid4, acc_last4, busy4, done4;

  int tests = 0;
  int fails = 0;

  logic [31:0] pw_t, sw_t, af_t, av_t, al_t, dn_t, bs_t, ar_t;

  always #5 clk = ~clk;

  mac_tile_sequencer #(.ARRAY_ROWS(4), .TILE_LEN_WIDTH(16), .ACC_LATENCY(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tile_len(tile_len), .abort(abort),
    .w_valid(w_valid), .w_ready(w_ready), .prepare_weight(prepare_weight),
    .set_weight(set_weight), .a_valid(a_valid), .a_ready(a_ready),
    .act_fire(act_fire), .acc_valid(acc_valid), .acc_last(acc_last),
    .busy(busy), .done(done)
  );

  mac_tile_sequencer #(.ARRAY_ROWS(4), .TILE_LEN_WIDTH(4), .ACC_LATENCY(2)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .tile_len(tile_len4), .abort(abort),
    .w_valid(w_valid), .w_ready(w_ready4), .prepare_weight(prepare_weight4),
    .set_weight(set_weight4), .a_valid(a_valid), .a_ready(a_ready4),
    .act_fire(act_fire4), .acc_valid(acc_valid4), .acc_last(acc_last4),
    .busy(busy4), .done(done4)
  );

  function automatic logic [31:0] m(input int lo, input int hi);
    logic [31:0] r;
    r = 32'h0;
    for (int i = lo; i <= hi; i++) r[i] = 1'b1;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Called #1 after a rising edge; drives one tile and records each cycle.
  task automatic run(input int ncyc, input logic sel, input logic [31:0] st_m,
                     input logic [15:0] len0, input logic [15:0] len_other,
                     input logic [31:0] wv_m, input logic [31:0] av_m,
                     input logic [31:0] ab_m);
    pw_t = 32'h0; sw_t = 32'h0; af_t = 32'h0; av_t = 32'h0;
    al_t = 32'h0; dn_t = 32'h0; bs_t = 32'h0; ar_t = 32'h0;
    for (int c = 0; c < ncyc; c++) begin
      start     = sel ? 1'b0 : st_m[c];
      start4    = sel ? st_m[c] : 1'b0;
      tile_len  = (c == 0) ? len0 : len_other;
      tile_len4 = len0[3:0];
      w_valid   = wv_m[c];
      a_valid   = av_m[c];
      abort     = ab_m[c];
      #1;
      pw_t[c] = sel ? prepare_weight4 : prepare_weight;
      sw_t[c] = sel ? set_weight4     : set_weight;
      af_t[c] = sel ? act_fire4       : act_fire;
      av_t[c] = sel ? acc_valid4      : acc_valid;
      al_t[c] = sel ? acc_last4       : acc_last;
      dn_t[c] = sel ? done4           : done;
      bs_t[c] = sel ? busy4           : busy;
      ar_t[c] = sel ? a_ready4        : a_ready;
      @(posedge clk);
      #1;
    end
    start = 1'b0; start4 = 1'b0; w_valid = 1'b0; a_valid = 1'b0; abort = 1'b0;
  endtask

  task automatic chk_tile(input string tag,
                          input logic [31:0] e_pw, input logic [31:0] e_sw,
                          input logic [31:0] e_af, input logic [31:0] e_av,
                          input logic [31:0] e_al, input logic [31:0] e_dn,
                          input logic [31:0] e_bs, input logic [31:0] e_ar);
    chk({tag, ".prepare_weight"}, pw_t, e_pw);
    chk({tag, ".set_weight"},     sw_t, e_sw);
    chk({tag, ".act_fire"},       af_t, e_af);
    chk({tag, ".acc_valid"},      av_t, e_av);
    chk({tag, ".acc_last"},       al_t, e_al);
    chk({tag, ".done"},           dn_t, e_dn);
    chk({tag, ".busy"},           bs_t, e_bs);
    chk({tag, ".a_ready"},        ar_t, e_ar);
  endtask

  function automatic logic [31:0] outs1();
    return {23'h0, w_ready, a_ready, prepare_weight, set_weight, act_fire,
            acc_valid, acc_last, busy, done};
  endfunction

  initial begin
    // Asynchronous reset asserted between clock edges.
    #2 rst_n = 1'b0;
    #1;
    chk("reset.outputs", outs1(), 32'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Baseline: tile_len=3, valids held high.
    run(14, 1'b0, 32'h1, 16'd3, 16'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
    chk_tile("base", m(1,4), m(5,5), m(6,8), m(8,10), m(10,10), m(10,10),
             m(1,10), m(6,8));

    // Weight backpressure: w_valid 1,0,1,0... from cycle 1; a_valid low in cycle 7.
    run(16, 1'b0, 32'h1, 16'd2, 16'd0, 32'hAAAA_AAAA, ~m(7,7), 32'h0);
    chk_tile("wstall", m(1,1) | m(3,3) | m(5,5) | m(7,7), m(8,8), m(9,10),
             m(11,12), m(12,12), m(12,12), m(1,12), m(9,10));

    // Activation stall inside STREAM: a_valid low in cycle 7, tile_len=3.
    run(14, 1'b0, 32'h1, 16'd3, 16'd0, 32'hFFFF_FFFF, ~m(7,7), 32'h0);
    chk_tile("astall", m(1,4), m(5,5), m(6,6) | m(8,9), m(8,8) | m(10,11),
             m(11,11), m(11,11), m(1,11), m(6,9));

    // Empty tile: ARM completes the tile directly.
    run(10, 1'b0, 32'h1, 16'd0, 16'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
    chk_tile("empty", m(1,4), m(5,5), 32'h0, 32'h0, 32'h0, m(5,5),
             m(1,5), 32'h0);

    // start with tile_len=9 during STREAM is ignored.
    run(14, 1'b0, m(0,0) | m(7,7), 16'd3, 16'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
    chk_tile("ignstart", m(1,4), m(5,5), m(6,8), m(8,10), m(10,10), m(10,10),
             m(1,10), m(6,8));

    // Abort in cycle 7 of the baseline tile.
    run(14, 1'b0, 32'h1, 16'd3, 16'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, m(7,7));
    chk_tile("abort", m(1,4), m(5,5), m(6,7), 32'h0, 32'h0, 32'h0,
             m(1,7), m(6,7));

    // Tile after abort runs normally again.
    run(14, 1'b0, 32'h1, 16'd1, 16'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
    chk_tile("postabort", m(1,4), m(5,5), m(6,6), m(8,8), m(8,8), m(8,8),
             m(1,8), m(6,6));

    // Reset mid-LOAD: outputs drop without waiting for a clock edge.
    run(2, 1'b0, 32'h1, 16'd3, 16'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
    w_valid = 1'b1;
    a_valid = 1'b1;
    #1;
    chk("rst.pre_prepare", {31'h0, prepare_weight}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst.async_outputs", outs1(), 32'h0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst.idle_after", outs1(), 32'h0);
    w_valid = 1'b0;
    a_valid = 1'b0;
    @(posedge clk);
    #1;

    // 4-bit length counter at its maximum: exactly 15 fires, last on the 15th.
    run(26, 1'b1, 32'h1, 16'd15, 16'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
    chk_tile("len15", m(1,4), m(5,5), m(6,20), m(8,22), m(22,22), m(22,22),
             m(1,22), m(6,20));
    chk("len15.fire_count", $countones(af_t), 32'd15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
